// File: rtl/alu_pkg.sv
// alu_pkg: ALU select encoding shared by decode, the ID/EX register and the ALU.
// Ports: none (package).
package alu_pkg;

    localparam int unsigned ALU_SEL_W = 5;

    typedef logic [ALU_SEL_W-1:0] alu_sel_t;

endpackage : alu_pkg

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the ID/EX pipeline register and its forwarding muxes.
// Ports: none (package).
package pipe_pkg;

    import alu_pkg::*;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    // WIDTH-independent part of the registered payload; operands and pc are
    // kept beside it because their width is a module parameter.
    typedef struct packed {
        alu_sel_t   sel;
        logic [31:0] imm;
        logic [4:0] rd_addr;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic       wb_en;
        logic       is_load;
    } id_ex_t;

endpackage : pipe_pkg

// File: rtl/id_ex_fwd_mux.sv
// fwd_mux: per-operand bypass select for the EX stage.
// Ports:
//   addr      in   source register index of the stored operand
//   stored    in   operand value captured at decode
//   mem_en/mem_addr/mem_data  in  MEM-stage bypass source
//   wb_en/wb_addr/wb_data     in  WB-stage bypass source
//   data      out  resolved operand
//   sel       out  which source was chosen
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [4:0]       addr,
    input  logic [WIDTH-1:0] stored,
    input  logic             mem_en,
    input  logic [4:0]       mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] data,
    output fwd_sel_e         sel
);

    // x0 never forwards; MEM is younger than WB so it wins.
    always_comb begin
        sel = FWD_NONE;
        if (addr != REG_X0) begin
            if (mem_en && (mem_addr == addr)) begin
                sel = FWD_MEM;
            end else if (wb_en && (wb_addr == addr)) begin
                sel = FWD_WB;
            end
        end
    end

    always_comb begin
        data = stored;
        case (sel)
            FWD_MEM: data = mem_data;
            FWD_WB:  data = wb_data;
            default: data = stored;
        endcase
    end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with valid/ready handshake,
// MEM/WB operand forwarding, load-use stall and synchronous flush.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   flush                 kill EX contents (branch/jump redirect)
//   id_valid / id_ready   decode-side handshake
//   id_*                  decoded instruction fields
//   ex_valid / ex_ready   execute-side handshake
//   ex_*                  registered instruction fields, operands forwarded
//   mem_fwd_*, wb_fwd_*   bypass sources from MEM and WB
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [4:0]       id_sel,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [31:0]      id_imm,
    input  logic [WIDTH-1:0] id_pc,
    input  logic             id_wb_en,
    input  logic             id_is_load,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [4:0]       ex_sel,
    output logic [WIDTH-1:0] ex_rs1,
    output logic [WIDTH-1:0] ex_rs2,
    output logic [31:0]      ex_imm,
    output logic [WIDTH-1:0] ex_pc,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_wb_en,
    output logic             ex_is_load,
    input  logic             mem_fwd_en,
    input  logic [4:0]       mem_fwd_addr,
    input  logic [WIDTH-1:0] mem_fwd_data,
    input  logic             wb_fwd_en,
    input  logic [4:0]       wb_fwd_addr,
    input  logic [WIDTH-1:0] wb_fwd_data
);

    id_ex_t           pl_q;
    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [WIDTH-1:0] pc_q;
    fwd_sel_e         rs1_fwd;
    fwd_sel_e         rs2_fwd;
    logic             hazard;
    logic             id_fire;
    logic             ex_fire;

    // Conservative: any rs match stalls, whether or not the operand is used.
    always_comb begin
        hazard = ex_valid && pl_q.is_load && pl_q.wb_en && (pl_q.rd_addr != REG_X0) &&
                 ((pl_q.rd_addr == id_rs1_addr) || (pl_q.rd_addr == id_rs2_addr));
    end

    assign id_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign id_fire  = id_valid && id_ready;
    assign ex_fire  = ex_valid && ex_ready;

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs1 (
        .addr     (pl_q.rs1_addr),
        .stored   (rs1_q),
        .mem_en   (mem_fwd_en),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_addr  (wb_fwd_addr),
        .wb_data  (wb_fwd_data),
        .data     (ex_rs1),
        .sel      (rs1_fwd)
    );

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs2 (
        .addr     (pl_q.rs2_addr),
        .stored   (rs2_q),
        .mem_en   (mem_fwd_en),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_addr  (wb_fwd_addr),
        .wb_data  (wb_fwd_data),
        .data     (ex_rs2),
        .sel      (rs2_fwd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            pl_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (id_fire) begin
            ex_valid      <= 1'b1;
            pl_q.sel      <= id_sel;
            pl_q.imm      <= id_imm;
            pl_q.rd_addr  <= id_rd_addr;
            pl_q.rs1_addr <= id_rs1_addr;
            pl_q.rs2_addr <= id_rs2_addr;
            pl_q.wb_en    <= id_wb_en;
            pl_q.is_load  <= id_is_load;
            rs1_q         <= id_rs1_data;
            rs2_q         <= id_rs2_data;
            pc_q          <= id_pc;
        end else if (ex_fire) begin
            ex_valid <= 1'b0;
        end else if (ex_valid) begin
            // Stalled: capture any bypassed value so it survives the producer
            // retiring out of WB. Unforwarded operands already equal rs*_q.
            if (rs1_fwd != FWD_NONE) rs1_q <= ex_rs1;
            if (rs2_fwd != FWD_NONE) rs2_q <= ex_rs2;
        end
    end

    assign ex_sel     = pl_q.sel;
    assign ex_imm     = pl_q.imm;
    assign ex_pc      = pc_q;
    assign ex_rd_addr = pl_q.rd_addr;
    assign ex_wb_en   = pl_q.wb_en;
    assign ex_is_load = pl_q.is_load;

endmodule : id_ex_stage

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the RV32I core; its outputs drive the ALU operand, select, immediate and pc inputs directly.
- Carries a valid/ready handshake and resolves RAW hazards by forwarding from the MEM and WB stages.
- Stalls upstream on a load-use hazard, inserting a bubble into EX.
- Supports a synchronous flush for branch/jump redirect.

Parameters:
- WIDTH, 32, datapath width of register operands, pc and forwarded data.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of EX contents.
- id_valid  in  1  decode slot holds an instruction.
- id_ready  out  1  this stage accepts the decode slot this cycle.
- id_sel  in  5  ALU select, alu_pkg encoding.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  WIDTH each  register-file read data.
- id_imm  in  32  decoded immediate.
- id_pc  in  WIDTH  instruction pc.
- id_wb_en  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- ex_valid  out  1  EX holds a live instruction.
- ex_ready  in  1  downstream (EX/MEM) accepts.
- ex_sel  out  5  to ALU sel.
- ex_rs1, ex_rs2  out  WIDTH each  forwarded operands, to ALU rs1/rs2.
- ex_imm  out  32  to ALU imm.
- ex_pc  out  WIDTH  to ALU pc.
- ex_rd_addr  out  5  destination register.
- ex_wb_en  out  1  EX writes rd.
- ex_is_load  out  1  EX is a load.
- mem_fwd_en  in  1  MEM stage holds a non-load result that writes rd.
- mem_fwd_addr  in  5  MEM destination register.
- mem_fwd_data  in  WIDTH  MEM result.
- wb_fwd_en  in  1  WB stage writes the register file this cycle.
- wb_fwd_addr  in  5  WB destination register.
- wb_fwd_data  in  WIDTH  WB write data.

Behaviour:
- Reset (async, rst_n low): ex_valid=0 and all payload registers (sel, rs1, rs2, imm, pc, rd_addr, rs1_addr, rs2_addr, wb_en, is_load) = 0. Release is sampled on clk.
- Definitions:
  - ex_fire = ex_valid & ex_ready.
  - id_fire = id_valid & id_ready.
- hazard = ex_valid & ex_is_load & ex_wb_en & (ex_rd_addr != 0) & ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr)). This is a conservative compare and applies regardless of operand use.
- id_ready = !flush & !hazard & (!ex_valid | ex_ready). Purely combinational; no dependence on id_valid.
- Register update priority on each rising edge:
  1. flush: ex_valid <= 0; payload don't-care. Any id_valid that cycle is dropped, because id_ready=0.
  2. id_fire: load all id_* fields, ex_valid <= 1. Latency is 1 cycle from id_fire to ex_valid.
  3. ex_fire without id_fire: ex_valid <= 0. A hazard in this case yields exactly one bubble.
  4. Otherwise (hold, i.e. ex_valid & !ex_ready): payload held, but the operand registers are refreshed with the current forwarded ex_rs1/ex_rs2. This keeps operands from going stale when a producer leaves WB during a stall.
- Forwarding, combinational, per operand, applied to the stored operand register using the stored source address:
  - If addr == 0: operand = stored value. No forwarding to x0.
  - Else if mem_fwd_en and mem_fwd_addr == addr: mem_fwd_data. MEM has priority over WB.
  - Else if wb_fwd_en and wb_fwd_addr == addr: wb_fwd_data.
  - Else: stored value.
- Forwarding is active even when ex_valid=0; outputs are don't-care then.
- ex_sel, ex_imm, ex_pc, ex_rd_addr, ex_wb_en and ex_is_load come straight from their registers, with no combinational path from id_*.
- Load-use stall: EX load followed by a dependent ID instruction gives id_ready=0 for every cycle the load remains in EX. When the load fires, EX becomes a bubble and the dependent instruction is accepted on the next cycle; its operand then resolves via mem_fwd/wb_fwd.
- The upstream contract requires id_* to be stable while id_valid & !id_ready.

Decomposition:
- pipe_pkg:
  - fwd_sel_e enum {FWD_NONE, FWD_MEM, FWD_WB}.
  - id_ex_t packed struct for the registered payload.
  - Constant REG_X0 = 5'd0.
  - Imports alu_pkg for the sel encoding width.
- Sub-module fwd_mux: one operand (addr, stored data, mem/wb sources → data, fwd_sel_e), instantiated twice.

Test Plan:
- Back-to-back fire, ex_ready=1:
  - Stimulus: addi x1 (rs1 data 5, imm 3) then add x2,x1,x1 with mem_fwd_en=1, mem_fwd_addr=1, mem_fwd_data=8.
  - Required: ex_rs1 = ex_rs2 = 8 in the cycle the second instruction is in EX; ex_valid held high for 2 cycles.
- Priority and x0:
  - Stimulus: mem_fwd and wb_fwd both target x3 (data 0xAA vs 0xBB), rs1=x3.
  - Required: ex_rs1 = 0xAA.
  - Stimulus: same, but rs1=x0 with stored value 0.
  - Required: ex_rs1 = 0.
- Load-use:
  - Stimulus: lw x4 in EX, ID add x5,x4,x0 valid.
  - Required: id_ready=0 for 1 cycle; next cycle ex_valid=0 (bubble); then add is accepted and ex_rs1 = wb_fwd_data (0x1234) when wb_fwd_addr=4.
- Downstream stall:
  - Stimulus: ex_ready=0 for 3 cycles; wb_fwd (x6=0x55) is active only in cycle 1.
  - Required: id_ready=0 throughout; payload stable; ex_rs1 remains 0x55 after the wb source deasserts.
- Flush:
  - Stimulus: flush=1 with ex_valid=1 and id_valid=1.
  - Required: id_ready=0; next cycle ex_valid=0; the ID instruction is never presented.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while ex_valid=1 and ex_ready=0.
  - Required: ex_valid=0 and all outputs 0 immediately, without a clock edge; after release, the first id_fire gives ex_valid=1 one cycle later.
